// File: rtl/rom_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_burst_arbiter
// Purpose  : Locks the reciprocal-coefficient ROM to one of two requesters
//            and streams a wrapping burst. The optional ROM_ARB_FIXED_PRIO_EN
//            macro makes req0 win every tie.
// Revision : 1.0
// ============================================================================
module rom_burst_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] len0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              rlast,
    output logic [DATA_W-1:0] rdata,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_beats_left;
    logic              r_rr_last;
    logic              r_rv_q;
    logic              r_rown_q;
    logic              r_rlast_q;

    logic              w_win;
    logic              w_start;
    logic              w_final_beat;
    logic [ADDR_W-1:0] w_start_addr;
    logic [ADDR_W-1:0] w_start_len;

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign w_win = ~req0;
`else
    // On a tie the requester that did not win last time gets the ROM.
    assign w_win = (req0 & req1) ? ~r_rr_last : req1;
`endif

    assign w_start      = rst_n & (r_state == ST_IDLE) & (req0 | req1);
    assign w_start_addr = w_win ? addr1 : addr0;
    assign w_start_len  = w_win ? len1 : len0;
    assign w_final_beat = (r_state == ST_BURST) && (r_beats_left == ADDR_W'(1));

    assign gnt0     = w_start & ~w_win;
    assign gnt1     = w_start & w_win;
    assign rom_en   = w_start | (rst_n & (r_state == ST_BURST));
    assign rom_addr = (r_state == ST_BURST) ? r_cur_addr : w_start_addr;
    assign busy     = (r_state == ST_BURST);

    assign rvalid0  = r_rv_q & ~r_rown_q;
    assign rvalid1  = r_rv_q & r_rown_q;
    assign rlast    = r_rlast_q;
    assign rdata    = rom_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_cur_addr   <= '0;
            r_beats_left <= '0;
            r_rr_last    <= 1'b1;
            r_rv_q       <= 1'b0;
            r_rown_q     <= 1'b0;
            r_rlast_q    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_owner      <= w_win;
                        r_cur_addr   <= w_start_addr + ADDR_W'(1);
                        r_beats_left <= w_start_len;
                        r_rr_last    <= w_win;
                        r_rv_q       <= 1'b1;
                        r_rown_q     <= w_win;
                        r_rlast_q    <= (w_start_len == '0);
                        r_state      <= (w_start_len == '0) ? ST_IDLE : ST_BURST;
                    end else begin
                        r_rv_q    <= 1'b0;
                        r_rlast_q <= 1'b0;
                    end
                end
                ST_BURST: begin
                    r_cur_addr   <= r_cur_addr + ADDR_W'(1);
                    r_beats_left <= r_beats_left - ADDR_W'(1);
                    r_rv_q       <= 1'b1;
                    r_rown_q     <= r_owner;
                    r_rlast_q    <= w_final_beat;
                    if (w_final_beat) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_burst_arbiter
// Purpose  : Directed vector table, corner sequences and randomized traffic
//            checked against a burst-schedule model of rom_burst_arbiter.
// Revision : 1.0
// ============================================================================
module tb_rom_burst_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
`ifdef ROM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, len0, addr1, len1;
    logic              gnt0, gnt1, rvalid0, rvalid1, rlast, rom_en, busy;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rdata, rom_dout;

    always #5 clk = ~clk;

    rom_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .len0(len0),
        .req1(req1), .addr1(addr1), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rlast(rlast), .rdata(rdata), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_dout(rom_dout), .busy(busy)
    );

    // Reciprocal ROM: entry k = 1/(k+1) in Q0.16, entry 0 saturated.
    function automatic logic [15:0] rom_val(input logic [3:0] k);
        if (k == 4'd0) return 16'hFFFF;
        return 16'(32'h10000 / (32'(k) + 32'd1));
    endfunction

    always_ff @(posedge clk) begin
        if (rom_en) rom_dout <= rom_val(rom_addr);
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       r0;
        logic [3:0] a0, l0;
        logic       r1;
        logic [3:0] a1, l1;
        logic [1:0] e_gnt;
        logic       e_en;
        logic [3:0] e_addr;
        logic [1:0] e_rv;
        logic       e_last;
        logic [15:0] e_data;
        logic       e_busy;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic r0, input logic [3:0] a0, input logic [3:0] l0,
                                input logic r1, input logic [3:0] a1, input logic [3:0] l1,
                                input logic [1:0] g, input logic en, input logic [3:0] ad,
                                input logic [1:0] rv, input logic lst, input logic [15:0] d,
                                input logic bsy);
        vec_t v;
        v = '{r0, a0, l0, r1, a1, l1, g, en, ad, rv, lst, d, bsy};
        return v;
    endfunction

    // ---------------- burst-schedule reference model ----------------
    typedef struct {
        int         c;
        logic       own;
        logic [3:0] addr;
        logic       last;
        logic       first;
    } issue_t;

    issue_t      sched[$];
    issue_t      prev;
    logic        prev_v  = 1'b0;
    logic        rr_prev = 1'b1;
    int          n_rv0   = 0;
    logic [15:0] last_data = 16'h0;

    // Called at the drive point of a cycle; checks mid-cycle, returns at the next drive point.
    task automatic model_cycle();
        logic [1:0] g;
        logic       has;
        logic       w;
        issue_t     cur;
        int         sl;
        logic [3:0] sa;
        @(negedge clk);
        g   = 2'b00;
        has = 1'b0;
        cur = '{default: 0};
        if (!rst_n) begin
            sched.delete();
            prev_v  = 1'b0;
            rr_prev = 1'b1;
            chk("rst_gnt", {30'd0, gnt1, gnt0}, 0);
            chk("rst_rom_en", {31'd0, rom_en}, 0);
            chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 0);
            chk("rst_busy", {31'd0, busy}, 0);
        end else begin
            if (sched.size() == 0 && (req0 || req1)) begin
                if (req0 && req1) w = FIXED ? 1'b0 : ~rr_prev;
                else              w = req1;
                g[w]    = 1'b1;
                rr_prev = w;
                sa = w ? addr1 : addr0;
                sl = int'(w ? len1 : len0);
                for (int i = 0; i <= sl; i++)
                    sched.push_back('{cyc + i, w, 4'(int'(sa) + i), (i == sl), (i == 0)});
            end
            if (sched.size() > 0 && sched[0].c == cyc) begin
                has = 1'b1;
                cur = sched.pop_front();
            end
            chk("gnt", {30'd0, gnt1, gnt0}, {30'd0, g});
            chk("rom_en", {31'd0, rom_en}, {31'd0, has});
            if (has) chk("rom_addr", {28'd0, rom_addr}, {28'd0, cur.addr});
            chk("busy", {31'd0, busy}, {31'd0, has && !cur.first});
            chk("rvalid", {30'd0, rvalid1, rvalid0},
                prev_v ? (prev.own ? 32'd2 : 32'd1) : 32'd0);
            chk("rlast", {31'd0, rlast}, {31'd0, prev_v && prev.last});
            if (prev_v) chk("rdata", {16'd0, rdata}, {16'd0, rom_val(prev.addr)});
            prev_v = has;
            prev   = cur;
        end
        if (rvalid0) n_rv0++;
        if (rlast) last_data = rdata;
        cyc++;
        @(posedge clk);
        #1;
        if (g[0]) req0 = 1'b0;
        if (g[1]) req1 = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        tv.push_back(mk(1, 2, 2, 0, 0, 0, 2'b01, 1, 2,  2'b00, 0, 16'h0000, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 3,  2'b01, 0, 16'h5555, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 4,  2'b01, 0, 16'h4000, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0,  2'b01, 1, 16'h3333, 0));
        tv.push_back(mk(0, 0, 0, 1, 14, 2, 2'b10, 1, 14, 2'b00, 0, 16'h0000, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 15, 2'b10, 0, 16'h1111, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0,  2'b10, 0, 16'h1000, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0,  2'b10, 1, 16'hFFFF, 0));
        tv.push_back(mk(1, 5, 0, 1, 6, 0, 2'b01, 1, 5,  2'b00, 0, 16'h0000, 0));
        tv.push_back(mk(0, 0, 0, 1, 6, 0, 2'b10, 1, 6,  2'b01, 1, 16'h2AAA, 0));
        tv.push_back(mk(1, 7, 0, 1, 8, 0, 2'b01, 1, 7,  2'b10, 1, 16'h2492, 0));
        tv.push_back(mk(0, 0, 0, 1, 8, 0, 2'b10, 1, 8,  2'b01, 1, 16'h2000, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0,  2'b10, 1, 16'h1C71, 0));
        tv.push_back(mk(1, 9, 0, 1, 10, 0, 2'b01, 1, 9, 2'b00, 0, 16'h0000, 0));
`ifdef ROM_ARB_FIXED_PRIO_EN
        tv.push_back(mk(1, 11, 0, 1, 10, 0, 2'b01, 1, 11, 2'b01, 1, 16'h1999, 0));
        tv.push_back(mk(0, 0, 0, 1, 10, 0, 2'b10, 1, 10, 2'b01, 1, 16'h1555, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0,  2'b10, 1, 16'h1745, 0));
`else
        tv.push_back(mk(1, 11, 0, 1, 10, 0, 2'b10, 1, 10, 2'b01, 1, 16'h1999, 0));
        tv.push_back(mk(1, 11, 0, 0, 0, 0, 2'b01, 1, 11, 2'b10, 1, 16'h1745, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0,  2'b01, 1, 16'h1555, 0));
`endif
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0,  2'b00, 0, 16'h0000, 0));
        tv.push_back(mk(1, 3, 3, 0, 0, 0, 2'b01, 1, 3,  2'b00, 0, 16'h0000, 0));
        tv.push_back(mk(0, 0, 0, 1, 12, 1, 2'b00, 1, 4, 2'b01, 0, 16'h4000, 1));
        tv.push_back(mk(0, 0, 0, 1, 12, 1, 2'b00, 1, 5, 2'b01, 0, 16'h3333, 1));
        tv.push_back(mk(0, 0, 0, 1, 12, 1, 2'b00, 1, 6, 2'b01, 0, 16'h2AAA, 1));
        tv.push_back(mk(0, 0, 0, 1, 12, 1, 2'b10, 1, 12, 2'b01, 1, 16'h2492, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 13, 2'b10, 0, 16'h13B1, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0,  2'b10, 1, 16'h1249, 0));

        // Reset with both requests raised: grants and reads must stay suppressed.
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        addr0 = '0; len0 = '0; addr1 = '0; len1 = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_gnt", {30'd0, gnt1, gnt0}, 0);
        chk("reset_rom_en", {31'd0, rom_en}, 0);
        chk("reset_rvalid", {30'd0, rvalid1, rvalid0}, 0);
        chk("reset_rlast", {31'd0, rlast}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            req0 = tv[i].r0; addr0 = tv[i].a0; len0 = tv[i].l0;
            req1 = tv[i].r1; addr1 = tv[i].a1; len1 = tv[i].l1;
            @(negedge clk);
            chk($sformatf("tv%0d_gnt", i), {30'd0, gnt1, gnt0}, {30'd0, tv[i].e_gnt});
            chk($sformatf("tv%0d_rom_en", i), {31'd0, rom_en}, {31'd0, tv[i].e_en});
            if (tv[i].e_en)
                chk($sformatf("tv%0d_rom_addr", i), {28'd0, rom_addr}, {28'd0, tv[i].e_addr});
            chk($sformatf("tv%0d_rvalid", i), {30'd0, rvalid1, rvalid0}, {30'd0, tv[i].e_rv});
            chk($sformatf("tv%0d_rlast", i), {31'd0, rlast}, {31'd0, tv[i].e_last});
            chk($sformatf("tv%0d_busy", i), {31'd0, busy}, {31'd0, tv[i].e_busy});
            if (tv[i].e_rv != 2'b00)
                chk($sformatf("tv%0d_rdata", i), {16'd0, rdata}, {16'd0, tv[i].e_data});
            cyc++;
            @(posedge clk);
            #1;
        end
        req0 = 1'b0; req1 = 1'b0;

        // Re-align model and DUT from reset.
        rst_n = 1'b0;
        model_cycle();
        rst_n = 1'b1;

        // Full 16-beat burst from address 0.
        req0 = 1'b1; addr0 = 4'd0; len0 = 4'd15;
        n_rv0 = 0;
        repeat (18) model_cycle();
        chk("full_beats", n_rv0, 16);
        chk("full_lastdata", {16'd0, last_data}, 32'h1000);

        // Reset in the third cycle of an 8-beat burst, then a fresh req1.
        req0 = 1'b1; addr0 = 4'd1; len0 = 4'd7;
        repeat (2) model_cycle();
        n_rv0 = 0;
        rst_n = 1'b0;
        repeat (2) model_cycle();
        rst_n = 1'b1;
        req1 = 1'b1; addr1 = 4'd4; len1 = 4'd1;
        repeat (4) model_cycle();
        chk("rst_mid_no_rv0", n_rv0, 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0  = 1'b1;
                addr0 = 4'($urandom);
                len0  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1  = 1'b1;
                addr1 = 4'($urandom);
                len1  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            end
            rst_n = ($urandom_range(0, 149) != 0);
            model_cycle();
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_burst_arbiter.md
# rom_burst_arbiter

Arbitrates read access to the 16-entry, 16-bit reciprocal-coefficient ROM (entry k holds 1/(k+1)) between two requesters, such as two series-evaluation datapaths. Each requester asks for a burst of consecutive coefficients. The block locks the ROM to the winning requester and walks the addresses with wrap-around. It returns a valid-qualified data stream that accounts for the ROM's one-cycle registered read. The block sits between the requesters and the ROM instance. The ROM's own synchronous reset is tied off at the top level.

## Interface
- ADDR_W, 4, ROM address width (beats per burst 1..2^ADDR_W)
- DATA_W, 16, ROM word width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  burst request, held until matching gnt
- addr0 / addr1  in  ADDR_W  burst start address, stable while req high
- len0 / len1  in  ADDR_W  burst length minus one
- gnt0 / gnt1  out  1  one-cycle acceptance pulse (combinational)
- rvalid0 / rvalid1  out  1  response beat valid for that requester
- rlast  out  1  final beat of current burst, qualified by rvalidX
- rdata  out  DATA_W  shared response data, = rom_dout
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_W  ROM read address
- rom_dout  in  DATA_W  ROM registered output
- busy  out  1  high while in BURST

## Operation
- States: IDLE, BURST. Registers: state, owner, cur_addr, beats_left, rr_last, rv_q, rown_q, rlast_q.
- IDLE with any req:
  - Pick the winner and assert gnt_w.
  - Issue the first read in the same cycle: rom_en=1, rom_addr=addr_w.
  - Latch owner=w, cur_addr=addr_w+1, beats_left=len_w.
  - If len_w=0, stay IDLE; otherwise go to BURST.
  - Update rr_last=w.
- BURST:
  - Each cycle: rom_en=1, rom_addr=cur_addr, cur_addr++, beats_left--.
  - On the beat where beats_left=1 the block issues its final read and goes to IDLE.
  - No gnt is asserted in BURST. The other requester waits; no preemption.
- Address increment is modulo 2^ADDR_W (15 wraps to 0).
- Round-robin: on simultaneous requests the winner is the requester that is not rr_last. rr_last resets to 1, so req0 wins the first tie. A lone requester always wins.
- Response pipeline: each issue sets rv_q=1, rown_q=owner and rlast_q=(final issue) for the next cycle.
  - rvalid0 = rv_q & (rown_q==0).
  - rvalid1 = rv_q & (rown_q==1).
  - rlast = rlast_q.
  - rdata = rom_dout.
- Back-to-back bursts: the IDLE cycle after a final issue may grant and issue immediately, giving zero bubbles. Its first response beat follows the previous rlast beat directly.
- rom_en=0 whenever no read is issued. The ROM then holds its last word; rdata is don't-care when no rvalid is asserted.

## Timing
- Latency: a read issued in cycle t returns rdata with rvalid in cycle t+1.
- A burst of len+1 beats occupies cycles t..t+len for issue and t+1..t+len+1 for response.
- gnt is combinational from req in IDLE. The requester drops req (or presents a new request) the cycle after gnt.
- Reset values:
  - Registers: state=IDLE, owner=0, cur_addr=0, beats_left=0, rr_last=1, rv_q=0, rlast_q=0.
  - Outputs: gnt0/1=0, rvalid0/1=0, rlast=0, rom_en=0, busy=0.
- While rst_n is low, gnt0/1 and rom_en are forced to 0.
- Reset mid-burst: the burst is abandoned and no further rvalid is produced. After release, arbitration restarts from IDLE with rr_last=1.

## Configuration
- ROM_ARB_FIXED_PRIO_EN defined: simultaneous requests in IDLE always grant req0. rr_last is still maintained but ignored.
- ROM_ARB_FIXED_PRIO_EN undefined: round-robin as described in Operation.

## Test plan
- Single burst: req0 addr0=2 len0=2 in cycle 0:
  - gnt0 in cycle 0.
  - rom_addr 2,3,4 in cycles 0–2.
  - rvalid0 in cycles 1–3 with rdata 5555, 4000, 3333.
  - rlast in cycle 3; busy in cycles 1–2.
- Wrap: req1 addr1=14 len1=2 -> rdata 1111, 1000, FFFF; rlast on FFFF.
- Tie and round-robin, both reqs held in cycle 0 with len=0:
  - After reset, gnt0 in cycle 0 and gnt1 in cycle 1.
  - Re-asserting both afterwards grants req0 then req1 again.
  - With ROM_ARB_FIXED_PRIO_EN, req0 wins every tie.
- Lockout: req1 raised in cycle 1 during a req0 burst with len0=3 -> gnt1 only in cycle 4, and req1's first rvalid1 in cycle 5, immediately after rvalid0+rlast in cycle 4.
- Full burst: addr0=0 len0=15 -> 16 beats FFFF..1000 in order; rlast only on beat 16 (1000).
- Reset mid-burst: rst_n low in cycle 2 of a len=7 burst -> rom_en=0 and rvalid0=0 from then on. After release, a new req1 is granted from IDLE.
